bsg_acm_input_packer: RTL and testbench

- Upstream stage of the ACM encryptor.
- Accepts a serial stream on a narrow valid/ready channel: one header beat carrying the iteration (frame) count, then dim_p*dim_p pixel beats.
- Assembles the stream into a full-image parallel vector plus a frame count.
- Offers both to the ACM controller/cell-array pair over a valid/ready handshake, one image at a time.

---
 rtl/bsg_acm_input_packer.sv | 99 +++++++++
 tb/tb_bsg_acm_input_packer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bsg_acm_input_packer.sv
// Serial-to-parallel front end for the ACM encryptor: a header beat with the frame count, then dim_p*dim_p pixels.
// Define BSG_ACM_PACKER_SAT_EN to saturate oversized headers at max_game_length_p instead of wrapping them.
module bsg_acm_input_packer #(
  parameter int width_p           = 8,
  parameter int dim_p             = 4,
  parameter int max_game_length_p = 16,
  parameter int chan_width_p      = 8,
  localparam int game_len_width_lp = ((max_game_length_p+1) == 1) ? 1 : $clog2(max_game_length_p+1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [chan_width_p-1:0]          data_i,
  input  logic                             v_i,
  output logic                             ready_o,
  output logic [dim_p*dim_p*width_p-1:0]   data_o,
  output logic [game_len_width_lp-1:0]     frames_o,
  output logic                             v_o,
  input  logic                             ready_i
);

  localparam int pix_lp           = dim_p*dim_p;
  localparam int pix_cnt_width_lp = (pix_lp == 1) ? 1 : $clog2(pix_lp);
  localparam logic [pix_cnt_width_lp-1:0] last_pix_lp = pix_cnt_width_lp'(pix_lp-1);

  if (chan_width_p < width_p || chan_width_p < game_len_width_lp) begin : g_bad_chan
    $error("chan_width_p must cover width_p and game_len_width_lp");
  end

  typedef enum logic [1:0] {eHDR, eLOAD, eFULL} state_e;

  state_e                               state_q, state_d;
  logic [pix_cnt_width_lp-1:0]          pix_cnt_q;
  logic [game_len_width_lp-1:0]         frames_q, frames_d, hdr_val;
  logic [pix_lp-1:0][width_p-1:0]       pix_q;
  logic                                 hdr_xfer, load_xfer;

  assign hdr_xfer  = v_i & (state_q == eHDR);
  assign load_xfer = v_i & (state_q == eLOAD);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= eHDR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      eHDR:    if (v_i) state_d = eLOAD;
      eLOAD:   if (v_i && pix_cnt_q == last_pix_lp) state_d = eFULL;
      eFULL:   if (ready_i) state_d = eHDR;
      default: state_d = eHDR;
    endcase
  end

  // Handshake outputs decode from the state register only.
  always_comb begin
    ready_o = 1'b0;
    v_o     = 1'b0;
    case (state_q)
      eHDR, eLOAD: ready_o = 1'b1;
      eFULL:       v_o     = 1'b1;
      default:     ;
    endcase
  end

  always_comb begin
`ifdef BSG_ACM_PACKER_SAT_EN
    if (data_i > chan_width_p'(max_game_length_p))
      hdr_val = game_len_width_lp'(max_game_length_p);
    else
      hdr_val = data_i[game_len_width_lp-1:0];
`else
    hdr_val = data_i[game_len_width_lp-1:0];
`endif
    // The controller cannot run zero iterations.
    frames_d = (hdr_val == '0) ? game_len_width_lp'(1) : hdr_val;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frames_q  <= game_len_width_lp'(1);
      pix_cnt_q <= '0;
    end else if (hdr_xfer) begin
      frames_q  <= frames_d;
      pix_cnt_q <= '0;
    end else if (load_xfer && pix_cnt_q != last_pix_lp) begin
      pix_cnt_q <= pix_cnt_q + 1'b1;
    end
  end

  // Pixel storage carries no reset; every slot is rewritten before v_o rises.
  always_ff @(posedge clk_i) begin
    if (!reset_i && load_xfer) pix_q[pix_cnt_q] <= data_i[width_p-1:0];
  end

  assign data_o   = pix_q;
  assign frames_o = frames_q;

endmodule

// File: tb/tb_bsg_acm_input_packer.sv
// Randomized bench for bsg_acm_input_packer against an image/frame-count reference model.
module tb_bsg_acm_input_packer;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int M  = 16;
  localparam int C  = 8;
  localparam int N  = D*D;
  localparam int GW = 5;
  localparam int IW = N*W;

  logic          clk_i = 1'b0;
  logic          reset_i, v_i, ready_i;
  logic [C-1:0]  data_i;
  logic          ready_o, v_o;
  logic [IW-1:0] data_o;
  logic [GW-1:0] frames_o;

  logic [W-1:0]  px [N];
  int            n_tests = 0;
  int            n_fail  = 0;

  bsg_acm_input_packer #(.width_p(W), .dim_p(D), .max_game_length_p(M), .chan_width_p(C)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .frames_o(frames_o), .v_o(v_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [GW-1:0] exp_frames(input int h);
    int v;
`ifdef BSG_ACM_PACKER_SAT_EN
    v = (h > M) ? M : h;
`else
    v = h % (1 << GW);
`endif
    if (v == 0) v = 1;
    return GW'(v);
  endfunction

  task automatic fill_px(input int mode, input int base);
    for (int k = 0; k < N; k++) px[k] = (mode == 0) ? W'(base + k) : W'($urandom);
  endtask

  // Streams one header + image, then drains it after 'stall' cycles of downstream backpressure.
  task automatic send_image(input int hdr, input int gaps, input int stall);
    logic [IW-1:0] exp_img;
    logic [GW-1:0] exp_f;
    exp_f = exp_frames(hdr);
    for (int k = 0; k < N; k++) exp_img[k*W +: W] = px[k];
    check("hdr_ready", IW'(ready_o), IW'(1));
    v_i = 1'b1; data_i = C'(hdr); ready_i = 1'($urandom); tick();
    for (int k = 0; k < N; k++) begin
      if (gaps != 0) begin
        int g = (gaps == 1) ? 1 : int'($urandom_range(0, 2));
        repeat (g) begin
          v_i = 1'b0; data_i = C'($urandom); ready_i = 1'($urandom); tick();
          check("gap_v_o", IW'(v_o), IW'(0));
        end
      end
      check("load_ready", IW'(ready_o), IW'(1));
      v_i = 1'b1; data_i = C'(px[k]); ready_i = 1'($urandom); tick();
      if (k < N-1) check("load_v_o", IW'(v_o), IW'(0));
    end
    v_i = 1'b0; ready_i = 1'b0;
    check("full_v_o",   IW'(v_o), IW'(1));
    check("full_ready", IW'(ready_o), IW'(0));
    check("image",      data_o, exp_img);
    check("frames",     IW'(frames_o), IW'(exp_f));
    for (int s = 0; s < stall; s++) begin
      v_i = 1'b1; data_i = 8'hAA; ready_i = 1'b0; tick();
      check("stall_v_o",   IW'(v_o), IW'(1));
      check("stall_ready", IW'(ready_o), IW'(0));
      check("stall_image", data_o, exp_img);
      check("stall_frames", IW'(frames_o), IW'(exp_f));
    end
    v_i = 1'b0; ready_i = 1'b1; tick();
    ready_i = 1'b0;
    check("post_v_o",   IW'(v_o), IW'(0));
    check("post_ready", IW'(ready_o), IW'(1));
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b0; data_i = '0;
    repeat (3) tick();
    check("rst_v_o",    IW'(v_o), IW'(0));
    check("rst_ready",  IW'(ready_o), IW'(1));
    check("rst_frames", IW'(frames_o), IW'(1));
    reset_i = 1'b0;

    fill_px(0, 8'h10); send_image(5, 0, 0);
    fill_px(1, 0);     send_image(9, 0, 10);
    fill_px(0, 8'h40); send_image(3, 1, 0);
    fill_px(1, 0);     send_image(0, 0, 0);
    fill_px(1, 0);     send_image(8'h1F, 2, 1);
    fill_px(1, 0);     send_image(8'h20, 0, 0);
    fill_px(1, 0);     send_image(8'h11, 0, 0);
    fill_px(1, 0);     send_image(M, 0, 0);

    // Abandon a partial image with reset, then load a fresh one.
    v_i = 1'b1; data_i = 8'd7; tick();
    for (int k = 0; k < 7; k++) begin data_i = C'($urandom); tick(); end
    v_i = 1'b0; reset_i = 1'b1; tick();
    reset_i = 1'b0;
    check("midrst_v_o",    IW'(v_o), IW'(0));
    check("midrst_ready",  IW'(ready_o), IW'(1));
    check("midrst_frames", IW'(frames_o), IW'(1));
    fill_px(0, 8'h80); send_image(2, 0, 0);

    // Back-to-back images, each with its one-cycle bubble.
    fill_px(1, 0); send_image(4, 0, 0);
    fill_px(1, 0); send_image(6, 0, 0);

    for (int i = 0; i < 20; i++) begin
      fill_px(1, 0);
      send_image(int'($urandom_range(0, 255)), 2, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
